// File: rtl/fcs_append.sv
// fcs_append: appends the IEEE 802.3 CRC-32 FCS to a TX byte stream with zero-latency pass-through.
// Build option FCS_PAD_EN: zero-pad short frames to MIN_LEN bytes before the FCS.
module fcs_append #(
    parameter int unsigned MIN_LEN = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;
    localparam logic [31:0] CrcPoly = 32'hEDB8_8320;

    // MIN_LEN has to fit the 6-bit saturating length counter.
    if (MIN_LEN < 1 || MIN_LEN > 63) begin : g_min_len_bad
        $error("fcs_append: MIN_LEN must be in 1..63");
    end

    typedef enum logic [1:0] {StPass, StPad, StFcs} state_e;

    state_e      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic        out_xfer;

    // Reflected CRC-32 update over one byte, LSB first.
    function automatic logic [31:0] crc_byte(logic [31:0] crc, logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

`ifdef FCS_PAD_EN
    localparam logic [6:0] MinLen = 7'(MIN_LEN);

    logic [5:0] len_q, len_d;
    logic [6:0] len_inc;
    logic [5:0] len_sat;

    assign len_inc = {1'b0, len_q} + 7'd1;
    assign len_sat = (len_q == 6'd63) ? len_q : len_inc[5:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q <= 6'd0;
        end else begin
            len_q <= len_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StPass;
            crc_q     <= CrcInit;
            fcs_idx_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            fcs_idx_q <= fcs_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        fcs_idx_d = fcs_idx_q;
`ifdef FCS_PAD_EN
        len_d     = len_q;
`endif
        // PASS behaviour is the default, also while in reset.
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
        out_last  = 1'b0;

        case (state_q)
            StPad: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                out_data  = 8'h00;
            end
            StFcs: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                out_data  = ~crc_q[{fcs_idx_q, 3'b000} +: 8];
                out_last  = (fcs_idx_q == 2'd3);
            end
            default: ;
        endcase

        out_xfer = out_valid & out_ready;

        if (clear) begin
            state_d   = StPass;
            crc_d     = CrcInit;
            fcs_idx_d = 2'd0;
`ifdef FCS_PAD_EN
            len_d     = 6'd0;
`endif
        end else if (out_xfer) begin
            case (state_q)
                StPass: begin
                    crc_d = crc_byte(crc_q, out_data);
`ifdef FCS_PAD_EN
                    len_d = len_sat;
                    if (in_last) begin
                        fcs_idx_d = 2'd0;
                        state_d   = (len_inc < MinLen) ? StPad : StFcs;
                    end
`else
                    if (in_last) begin
                        fcs_idx_d = 2'd0;
                        state_d   = StFcs;
                    end
`endif
                end
`ifdef FCS_PAD_EN
                StPad: begin
                    crc_d = crc_byte(crc_q, out_data);
                    len_d = len_sat;
                    if (len_inc == MinLen) begin
                        fcs_idx_d = 2'd0;
                        state_d   = StFcs;
                    end
                end
`endif
                StFcs: begin
                    fcs_idx_d = fcs_idx_q + 2'd1;
                    if (fcs_idx_q == 2'd3) begin
                        state_d   = StPass;
                        crc_d     = CrcInit;
                        fcs_idx_d = 2'd0;
`ifdef FCS_PAD_EN
                        len_d     = 6'd0;
`endif
                    end
                end
                default: begin
                    state_d = StPass;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fcs_append.sv
// Self-checking bench for fcs_append: vector table, hand-written reset/clear/stall sequences and
// randomized frames checked against a frame-level CRC-32 model.
module tb_fcs_append;

    localparam int unsigned MinLen = 60;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [7:0] in_d;
        logic       in_v;
        logic       in_l;
        logic       rdy;
        logic [7:0] e_d;
        logic       e_v;
        logic       e_ir;
        logic       e_last;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    fcs_append #(.MIN_LEN(MinLen)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Bit-serial reflected CRC-32 over a whole byte sequence.
    function automatic logic [31:0] crc32(byte_q_t q);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    function automatic byte_q_t expected_frame(byte_q_t f);
        byte_q_t     q;
        logic [31:0] c;
        q = f;
`ifdef FCS_PAD_EN
        while (q.size() < int'(MinLen)) q.push_back(8'h00);
`endif
        c = ~crc32(q);
        for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
        return q;
    endfunction

    task automatic compare_frame(input string name, input byte_q_t got, input byte_q_t exp);
        int first;
        first = -1;
        total++;
        for (int i = 0; i < exp.size() && first < 0; i++) begin
            if (i >= got.size() || got[i] !== exp[i]) first = i;
        end
        if (first < 0 && got.size() != exp.size()) first = exp.size();
        if (first >= 0) begin
            bad++;
            $display("FAIL %s: got %0d bytes (byte %0d = %0h), required %0d bytes (byte %0d = %0h)",
                     name, got.size(), first, (first < got.size()) ? got[first] : 8'hxx,
                     exp.size(), first, (first < exp.size()) ? exp[first] : 8'hxx);
        end
    endtask

    task automatic idle_inputs();
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        out_ready = 1'b1;
    endtask

    // Drives one frame with random source gaps and sink stalls; collects emitted bytes up to out_last.
    task automatic run_frame(input string name, input byte_q_t f, input int stall_pct,
                             input int gap_pct, output byte_q_t got);
        int         idx;
        int         cyc;
        int         unstable;
        bit         done;
        bit         presenting;
        bit         prev_stall;
        logic [7:0] prev_d;
        idx = 0; cyc = 0; unstable = 0; done = 0; presenting = 0; prev_stall = 0; prev_d = 8'h00;
        got = {};
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            clear = 1'b0;
            if (!presenting && idx < f.size() && int'($urandom_range(99)) >= gap_pct)
                presenting = 1;
            in_valid  = presenting;
            in_data   = presenting ? f[idx] : 8'($urandom);
            in_last   = presenting && (idx == f.size() - 1);
            out_ready = int'($urandom_range(99)) >= stall_pct;
            #1;
            if (prev_stall && out_valid && out_data !== prev_d) unstable++;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (out_last) done = 1;
            end
            if (in_valid && in_ready) begin
                idx++;
                presenting = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
        end
        check({name, " finished"}, 32'(done), 32'd1);
        check({name, " stall stability"}, 32'(unstable), 32'd0);
    endtask

    initial begin
        byte_q_t golden, exp, got, frame, tail;
        vec_t    tbl[$];
        vec_t    v;
        string   s;
        int      n;

        s = "123456789";
        for (int i = 0; i < s.len(); i++) golden.push_back(s[i]);

        // Reset state: outputs follow PASS rules while reset is held.
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd1);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_data", 32'(out_data), 32'h5A);
        check("reset out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;

        // Vector table: PASS corner cases, golden frame, then pad/FCS tail, then back in PASS.
        v = '{in_d: 8'hAA, in_v: 0, in_l: 0, rdy: 1, e_d: 8'h00, e_v: 0, e_ir: 1, e_last: 0};
        tbl.push_back(v);
        v = '{in_d: 8'h55, in_v: 1, in_l: 0, rdy: 0, e_d: 8'h55, e_v: 1, e_ir: 0, e_last: 0};
        tbl.push_back(v);
        v = '{in_d: 8'h33, in_v: 0, in_l: 0, rdy: 0, e_d: 8'h00, e_v: 0, e_ir: 0, e_last: 0};
        tbl.push_back(v);
        foreach (golden[i]) begin
            v = '{in_d: golden[i], in_v: 1, in_l: (i == golden.size() - 1), rdy: 1,
                  e_d: golden[i], e_v: 1, e_ir: 1, e_last: 0};
            tbl.push_back(v);
        end
`ifdef FCS_PAD_EN
        exp = expected_frame(golden);
        for (int i = golden.size(); i < exp.size(); i++) tail.push_back(exp[i]);
`else
        tail = '{8'h26, 8'h39, 8'hF4, 8'hCB};
`endif
        foreach (tail[i]) begin
            v = '{in_d: 8'hEE, in_v: 1, in_l: 1, rdy: 1, e_d: tail[i], e_v: 1, e_ir: 0,
                  e_last: (i == tail.size() - 1)};
            tbl.push_back(v);
        end
        v = '{in_d: 8'h11, in_v: 0, in_l: 0, rdy: 1, e_d: 8'h00, e_v: 0, e_ir: 1, e_last: 0};
        tbl.push_back(v);

        foreach (tbl[i]) begin
            @(negedge clk);
            in_data = tbl[i].in_d; in_valid = tbl[i].in_v; in_last = tbl[i].in_l;
            out_ready = tbl[i].rdy;
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_v));
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            check($sformatf("vec%0d out_last", i), 32'(out_last), 32'(tbl[i].e_last));
            if (tbl[i].e_v) check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].e_d));
        end
        @(negedge clk);
        idle_inputs();

        // Golden frame with random back-pressure.
        run_frame("stalled golden", golden, 50, 0, got);
        compare_frame("stalled golden", got, expected_frame(golden));

        // Reset while FCS byte index 1 is on the output.
        exp = expected_frame(golden);
        n = exp.size() - 3;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (i < golden.size());
            in_data   = (i < golden.size()) ? golden[i] : 8'h00;
            in_last   = (i == golden.size() - 1);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        check("pre-reset fcs1 data", 32'(out_data), 32'(exp[n]));
        check("pre-reset fcs1 last", 32'(out_last), 32'd0);
        reset = 1'b1;
        #1;
        check("mid-fcs reset out_valid", 32'(out_valid), 32'd0);
        check("mid-fcs reset in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_frame("after reset", golden, 0, 0, got);
        compare_frame("after reset", got, exp);

        // clear on payload byte 5: byte still passes through, state is discarded.
        s = "ABCDEFGH";
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = s[i]; in_last = 1'b0; out_ready = 1'b1;
            clear = (i == 4);
            #1;
            if (i == 4) begin
                check("clear in_ready", 32'(in_ready), 32'd1);
                check("clear out_data", 32'(out_data), 32'(s[i]));
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("after clear out_valid", 32'(out_valid), 32'd0);
        run_frame("after clear", golden, 0, 0, got);
        compare_frame("after clear", got, expected_frame(golden));

        // Length boundaries, then random frames.
        for (int k = 0; k < 40; k++) begin
            int lens[8] = '{1, 2, MinLen - 1, MinLen, MinLen + 1, 63, 64, 70};
            int len;
            len = (k < 8) ? lens[k] : int'($urandom_range(1, 80));
            frame = {};
            for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
            run_frame($sformatf("rand%0d len%0d", k, len), frame,
                      int'($urandom_range(0, 60)), int'($urandom_range(0, 40)), got);
            compare_frame($sformatf("rand%0d len%0d", k, len), got, expected_frame(frame));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
